// File: rtl/ibexc_trace_pkg.sv
// Shared types for the RVFI trace packer: the stored record, header bit positions
// and the serializer state encoding.
package ibexc_trace_pkg;

    typedef struct packed {
        logic        drop;
        logic        trap;
        logic        intr;
        logic [4:0]  rd_addr;
        logic [15:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
    } trace_rec_t;

    localparam int unsigned TRACE_REC_W   = $bits(trace_rec_t);

    localparam int unsigned HDR_DROP_BIT  = 31;
    localparam int unsigned HDR_TRAP_BIT  = 30;
    localparam int unsigned HDR_INTR_BIT  = 29;
    localparam int unsigned HDR_RD_LSB    = 24;
    localparam int unsigned HDR_ORDER_LSB = 0;

    typedef enum logic [2:0] {
        SER_IDLE  = 3'd0,
        SER_HDR   = 3'd1,
        SER_PC    = 3'd2,
        SER_INSN  = 3'd3,
        SER_WDATA = 3'd4
    } ser_state_e;

    // Bits [23:16] of the header are reserved and always zero.
    function automatic logic [31:0] pack_hdr(input trace_rec_t rec);
        logic [31:0] hdr;
        hdr                        = '0;
        hdr[HDR_DROP_BIT]          = rec.drop;
        hdr[HDR_TRAP_BIT]          = rec.trap;
        hdr[HDR_INTR_BIT]          = rec.intr;
        hdr[HDR_RD_LSB +: 5]       = rec.rd_addr;
        hdr[HDR_ORDER_LSB +: 16]   = rec.order;
        return hdr;
    endfunction

endpackage

// File: rtl/ibexc_trace_fifo.sv
// Synchronous record FIFO; pointers wrap modulo Depth and a separate occupancy
// counter drives full/empty/level.
module ibexc_trace_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrW:0]   level_o
);

    localparam logic [AddrW:0] FullLvl = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   level_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == FullLvl);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/ibexc_rvfi_trace_packer.sv
// Captures RVFI retirements into a record FIFO and streams each record as four
// 32-bit beats (HDR, PC, INSN, WDATA), counting records lost to a full FIFO.
module ibexc_rvfi_trace_packer
    import ibexc_trace_pkg::*;
#(
    parameter int unsigned Depth = 8,
    localparam int unsigned LvlW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            trace_en_i,
    input  logic            rvfi_valid,
    input  logic [63:0]     rvfi_order,
    input  logic [31:0]     rvfi_insn,
    input  logic [31:0]     rvfi_pc_rdata,
    input  logic [31:0]     rvfi_rd_wdata,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic            rvfi_trap,
    input  logic            rvfi_intr,
    output logic            trc_valid_o,
    input  logic            trc_ready_i,
    output logic [31:0]     trc_data_o,
    output logic            trc_last_o,
    output logic [15:0]     drop_cnt_o,
    input  logic            drop_clr_i,
    output logic [LvlW-1:0] level_o,
    output ser_state_e      dbg_state_o
);

    // Stream handshake: a beat transfers on a rising edge where trc_valid_o && trc_ready_i;
    // once valid is raised, data and last hold until that transfer.
    ser_state_e      state_q;
    trace_rec_t      head_rec;
    trace_rec_t      new_rec;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LvlW-1:0] fifo_level;
    logic            cap_req, pop, can_write, push, drop;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            pending_drop_q, pending_drop_d;
    logic            unused_order;

    assign unused_order = ^rvfi_order[63:16];

    assign cap_req   = rvfi_valid && trace_en_i;
    assign pop       = (state_q == SER_WDATA) && trc_ready_i;
    assign can_write = !fifo_full || pop;
    assign push      = cap_req && can_write;
    assign drop      = cap_req && !can_write;

    assign new_rec = '{
        drop:     pending_drop_q,
        trap:     rvfi_trap,
        intr:     rvfi_intr,
        rd_addr:  rvfi_rd_addr,
        order:    rvfi_order[15:0],
        pc:       rvfi_pc_rdata,
        insn:     rvfi_insn,
        rd_wdata: rvfi_rd_wdata
    };

    ibexc_trace_fifo #(
        .Width (TRACE_REC_W),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (new_rec),
        .pop_i   (pop),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Leaving IDLE on the pushing edge itself gives the one-cycle capture-to-HDR latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SER_IDLE;
        end else begin
            case (state_q)
                SER_IDLE:  if (!fifo_empty || push) state_q <= SER_HDR;
                SER_HDR:   if (trc_ready_i) state_q <= SER_PC;
                SER_PC:    if (trc_ready_i) state_q <= SER_INSN;
                SER_INSN:  if (trc_ready_i) state_q <= SER_WDATA;
                SER_WDATA: if (trc_ready_i) begin
                    state_q <= ((fifo_level > LvlW'(1)) || push) ? SER_HDR : SER_IDLE;
                end
                default:   state_q <= SER_IDLE;
            endcase
        end
    end

    always_comb begin
        drop_cnt_d     = drop_cnt_q;
        pending_drop_d = pending_drop_q;
        if (drop_clr_i) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (drop) begin
            pending_drop_d = 1'b1;
        end else if (push) begin
            pending_drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q     <= '0;
            pending_drop_q <= 1'b0;
        end else begin
            drop_cnt_q     <= drop_cnt_d;
            pending_drop_q <= pending_drop_d;
        end
    end

    // The head entry is stable until the WDATA pop, so beats need no extra staging.
    always_comb begin
        trc_data_o = '0;
        case (state_q)
            SER_HDR:   trc_data_o = pack_hdr(head_rec);
            SER_PC:    trc_data_o = head_rec.pc;
            SER_INSN:  trc_data_o = head_rec.insn;
            SER_WDATA: trc_data_o = head_rec.rd_wdata;
            default:   trc_data_o = '0;
        endcase
    end

    assign trc_valid_o = (state_q != SER_IDLE);
    assign trc_last_o  = (state_q == SER_WDATA);
    assign drop_cnt_o  = drop_cnt_q;
    assign level_o     = fifo_level;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ibexc_rvfi_trace_packer.sv
// Bench for ibexc_rvfi_trace_packer: directed vector table, hand sequences for
// full/drop/reset corners, and random traffic against a record-queue model.
module tb_ibexc_rvfi_trace_packer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, rv, rdy, clr;
    logic [63:0] order_in;
    logic [31:0] pc_in, insn_in, wd_in;
    logic [4:0]  rd_in;
    logic        trap_in, intr_in;
    logic        trc_valid, trc_last;
    logic [31:0] trc_data;
    logic [15:0] drop_cnt;
    logic [3:0]  level;
    ibexc_trace_pkg::ser_state_e dbg_state;

    always #5 clk = ~clk;

    ibexc_rvfi_trace_packer #(.Depth(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .trace_en_i    (en),
        .rvfi_valid    (rv),
        .rvfi_order    (order_in),
        .rvfi_insn     (insn_in),
        .rvfi_pc_rdata (pc_in),
        .rvfi_rd_wdata (wd_in),
        .rvfi_rd_addr  (rd_in),
        .rvfi_trap     (trap_in),
        .rvfi_intr     (intr_in),
        .trc_valid_o   (trc_valid),
        .trc_ready_i   (rdy),
        .trc_data_o    (trc_data),
        .trc_last_o    (trc_last),
        .drop_cnt_o    (drop_cnt),
        .drop_clr_i    (clr),
        .level_o       (level),
        .dbg_state_o   (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of whole records ----------------
    typedef struct {
        bit        drop, trap, intr;
        bit [4:0]  rd;
        bit [15:0] order;
        bit [31:0] pc, insn, wd;
    } mrec_t;

    mrec_t     m_q[$];
    int        m_idx;       // beat index of the head record
    int        m_cnt;
    bit        m_pend;
    bit [15:0] next_order;
    bit        gap_en, have_last;
    bit [15:0] last_ord;
    bit        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    function automatic logic [31:0] m_beat(input mrec_t r, input int idx);
        case (idx)
            0:       return {r.drop, r.trap, r.intr, r.rd, 8'h00, r.order};
            1:       return r.pc;
            2:       return r.insn;
            default: return r.wd;
        endcase
    endfunction

    task automatic new_rec();
        order_in        = {$urandom, $urandom};
        order_in[15:0]  = next_order;
        next_order      = next_order + 16'd1;
        pc_in           = $urandom;
        insn_in         = $urandom;
        wd_in           = $urandom;
        rd_in           = 5'($urandom_range(0, 31));
        trap_in         = 1'($urandom_range(0, 1));
        intr_in         = 1'($urandom_range(0, 1));
    endtask

    // One clock: check outputs against the model at negedge, then advance the model.
    task automatic cycle();
        bit    exp_valid, hs, pop, can, dropped;
        mrec_t r;
        @(negedge clk);
        exp_valid = (m_q.size() != 0);
        chk("valid", trc_valid, exp_valid);
        chk("last", trc_last, exp_valid && (m_idx == 3));
        chk("level", level, m_q.size());
        chk("drop_cnt", drop_cnt, m_cnt);
        if (exp_valid) chk("data", trc_data, m_beat(m_q[0], m_idx));
        if (prev_stall) begin
            chk("stall_data", trc_data, prev_data);
            chk("stall_last", trc_last, prev_last);
        end
        hs = exp_valid && rdy;
        if (gap_en && hs && m_idx == 0) begin
            if (have_last && !trc_data[31]) chk("order_gap", trc_data[15:0], last_ord + 16'd1);
            last_ord  = trc_data[15:0];
            have_last = 1'b1;
        end
        prev_stall = exp_valid && !rdy;
        prev_data  = trc_data;
        prev_last  = trc_last;
        pop     = hs && (m_idx == 3);
        can     = (m_q.size() < DEPTH) || pop;
        dropped = 1'b0;
        if (hs) begin
            if (m_idx == 3) begin
                void'(m_q.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (rv && en) begin
            if (can) begin
                r = '{drop: m_pend, trap: trap_in, intr: intr_in, rd: rd_in,
                      order: order_in[15:0], pc: pc_in, insn: insn_in, wd: wd_in};
                m_q.push_back(r);
                m_pend = 1'b0;
            end else begin
                dropped = 1'b1;
                m_pend  = 1'b1;
            end
        end
        if (clr) m_cnt = dropped ? 1 : 0;
        else if (dropped && m_cnt < 16'hFFFF) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = 1'b0; clr = 1'b0; rdy = 1'b0; en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", trc_valid, 1'b0);
        chk("rst_last", trc_last, 1'b0);
        chk("rst_data", trc_data, 32'h0);
        chk("rst_level", level, 4'd0);
        chk("rst_drop", drop_cnt, 16'h0);
        chk("rst_state", dbg_state, ibexc_trace_pkg::SER_IDLE);
        m_q.delete();
        m_idx = 0; m_cnt = 0; m_pend = 1'b0;
        have_last = 1'b0; prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0; rv = 1'b0; rdy = 1'b1; clr = 1'b0;
        while (m_q.size() != 0 && g < 300) begin
            cycle();
            g++;
        end
        chk("drain_valid", trc_valid, 1'b0);
        chk("drain_level", level, 4'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit        rv;
        bit [15:0] ord;
        bit        trap, intr;
        bit [4:0]  rd;
        bit [31:0] pc, insn, wd;
        bit        rdy;
        bit        ev;
        bit [31:0] ed;
        bit        el;
        int        elev;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit v, bit [15:0] o, bit t, bit i, bit [4:0] rd, bit [31:0] pc,
                                bit [31:0] insn, bit [31:0] wd, bit r, bit ev, bit [31:0] ed,
                                bit el, int elev);
        vec_t x;
        x = '{v, o, t, i, rd, pc, insn, wd, r, ev, ed, el, elev};
        return x;
    endfunction

    initial begin
        int   rate;
        logic [31:0] hdr_seen;
        rst = 1'b1; en = 1'b1; rv = 1'b0; rdy = 1'b0; clr = 1'b0;
        order_in = '0; pc_in = '0; insn_in = '0; wd_in = '0; rd_in = '0;
        trap_in = 1'b0; intr_in = 1'b0;
        next_order = 16'd0; gap_en = 1'b0;

        tbl[0]  = mk(1, 16'h0005, 0, 0, 5'h00, 32'h8000_0000, 32'h0000_0013, 32'h0, 1, 0, 32'h0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0005, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0000, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0013, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0000, 1, 1);
        tbl[5]  = mk(1, 16'h1234, 1, 0, 5'h1F, 32'h0000_0100, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0, 32'h0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5F00_1234, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5F00_1234, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5F00_1234, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0100, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_F00D, 1, 1);
        tbl[12] = mk(1, 16'hFFFF, 0, 1, 5'h03, 32'h4, 32'h8, 32'hC, 1, 0, 32'h0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2300_FFFF, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0004, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0008, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_000C, 1, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);

        do_reset();

        for (int i = 0; i < 18; i++) begin
            rv = tbl[i].rv; rdy = tbl[i].rdy;
            order_in = {48'hABCD_0000_1111, tbl[i].ord};
            trap_in = tbl[i].trap; intr_in = tbl[i].intr; rd_in = tbl[i].rd;
            pc_in = tbl[i].pc; insn_in = tbl[i].insn; wd_in = tbl[i].wd;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), trc_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_last", i), trc_last, tbl[i].el);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].elev);
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), trc_data, tbl[i].ed);
            @(posedge clk);
            #1;
        end

        // Overflow: 10 retirements into a stalled 8-deep FIFO.
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rv = 1'b1; new_rec(); cycle();
        end
        rv = 1'b0;
        chk("ovf_level", level, 4'd8);
        chk("ovf_drop", drop_cnt, 16'd2);
        drain();
        rv = 1'b1; new_rec(); cycle(); rv = 1'b0;
        chk("ovf_hdr_valid", trc_valid, 1'b1);
        hdr_seen = trc_data;
        chk("ovf_hdr_dropbit", hdr_seen[31], 1'b1);
        drain();

        // Full FIFO, retirement lands on the WDATA handshake.
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rv = 1'b1; new_rec(); cycle();
        end
        rv = 1'b0;
        chk("full_level", level, 4'd8);
        rdy = 1'b1;
        for (int g = 0; g < 10 && m_idx != 3; g++) cycle();
        chk("full_at_wdata", trc_last, 1'b1);
        rv = 1'b1; new_rec(); cycle(); rv = 1'b0;
        chk("full_same_cycle_drop", drop_cnt, 16'd0);
        chk("full_same_cycle_level", level, 4'd8);
        drain();

        // Reset during the PC beat.
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rv = 1'b1; new_rec(); cycle();
        end
        rv = 1'b0; rdy = 1'b1;
        cycle();
        chk("pre_rst_pc_beat", dbg_state, ibexc_trace_pkg::SER_PC);
        chk("pre_rst_drop", drop_cnt, 16'd1);
        rst = 1'b1;
        #2;
        chk("midrst_valid", trc_valid, 1'b0);
        chk("midrst_level", level, 4'd0);
        chk("midrst_drop", drop_cnt, 16'd0);
        chk("midrst_last", trc_last, 1'b0);
        do_reset();
        rv = 1'b1; new_rec(); rdy = 1'b1; cycle(); rv = 1'b0;
        chk("post_rst_valid", trc_valid, 1'b1);
        drain();

        // Random traffic with capture always enabled; orders must be contiguous.
        do_reset();
        gap_en = 1'b1;
        rate = 2;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) rate = $urandom_range(0, 3);
            rdy = ($urandom_range(0, 3) < rate);
            rv  = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if (rv) new_rec();
            cycle();
        end
        clr = 1'b0;
        drain();
        gap_en = 1'b0;

        // Random traffic with trace_en toggling; stored records must still drain.
        for (int i = 0; i < 500; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 1) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if (rv) new_rec();
            cycle();
        end
        en = 1'b0; rv = 1'b1; clr = 1'b0;
        drain();
        en = 1'b1;

        // Saturation of the drop counter, then clear coinciding with a drop.
        do_reset();
        rdy = 1'b0; rv = 1'b1;
        for (int i = 0; i < DEPTH + 65535; i++) cycle();
        chk("sat_reach", drop_cnt, 16'hFFFF);
        cycle();
        chk("sat_hold", drop_cnt, 16'hFFFF);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("clr_with_drop", drop_cnt, 16'd1);
        rv = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibexc_rvfi_trace_packer.md
IBEXC_RVFI_TRACE_PACKER -- requirements
Module: ibexc_rvfi_trace_packer

Interface
REQ-001 SHALL have parameter Depth, default 8, record FIFO depth (power of two, >=2).
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 clk_i  in  1  core clock; all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 trace_en_i  in  1  capture enable.
REQ-006 rvfi_valid  in  1  retirement strobe from the core RVFI port.
REQ-007 rvfi_order  in  64  retirement order; only bits [15:0] are used.
REQ-008 rvfi_insn, rvfi_pc_rdata, rvfi_rd_wdata  in  32 each  retired instruction, its PC, and the rd write data.
REQ-009 rvfi_rd_addr  in  5  destination register.
REQ-010 rvfi_trap, rvfi_intr  in  1 each  trap flag and interrupt-entry flag.
REQ-011 trc_valid_o / trc_ready_i  out / in  1 each  output stream handshake.
REQ-012 trc_data_o  out  32  stream beat.
REQ-013 trc_last_o  out  1  marks the final beat of a record.
REQ-014 drop_cnt_o  out  16  saturating count of dropped records.
REQ-015 drop_clr_i  in  1  single-cycle pulse that clears drop_cnt_o.
REQ-016 level_o  out  $clog2(Depth)+1  FIFO occupancy.

Function
REQ-017 SHALL capture one record on a clock edge where rvfi_valid && trace_en_i and the FIFO can accept a write.
REQ-018 A record SHALL contain order[15:0], trap, intr, rd_addr, pc, insn, rd_wdata, and a drop flag.
REQ-019 The FIFO can accept a write when it is not full, or when it is full and the final beat of its head record handshakes in the same cycle.
REQ-020 When capture is requested but the FIFO cannot accept a write:
- the record SHALL be discarded;
- drop_cnt_o SHALL increment, saturating at 16'hFFFF;
- internal pending_drop SHALL be set.
REQ-021 The next record actually stored SHALL carry drop=pending_drop, and pending_drop SHALL clear in that same cycle.
REQ-022 If drop_clr_i coincides with a drop, drop_cnt_o SHALL become 1.
REQ-023 Each record SHALL be emitted as 4 beats in the order HDR, PC, INSN, WDATA.
REQ-024 Header beat layout:
- [31] drop
- [30] trap
- [29] intr
- [28:24] rd_addr
- [23:16] 0
- [15:0] order
REQ-025 Serializer FSM:
- states IDLE, HDR, PC, INSN, WDATA;
- IDLE->HDR when the FIFO is non-empty;
- each state advances only on trc_valid_o && trc_ready_i;
- WDATA->HDR if another record remains after the pop, otherwise WDATA->IDLE.
REQ-026 trc_valid_o SHALL be high in HDR..WDATA and low in IDLE.
REQ-027 trc_last_o SHALL be high only in WDATA.
REQ-028 trc_data_o and trc_last_o SHALL hold stable while trc_valid_o && !trc_ready_i.
REQ-029 Latency: a record captured at edge N into an empty, idle block SHALL present its HDR beat with trc_valid_o=1 in the cycle after edge N.
REQ-030 The FIFO entry SHALL be popped on the WDATA handshake, and level_o SHALL reflect the pop at the next edge.
REQ-031 Deasserting trace_en_i SHALL stop new captures only; stored and in-flight records SHALL still drain completely.
REQ-032 Pointer wrap SHALL be modulo Depth, with a separate occupancy count for full and empty.
REQ-033 A simultaneous push and pop SHALL leave level_o unchanged.

Reset
REQ-034 While rst_i is high, the following SHALL be held:
- FSM=IDLE;
- FIFO empty;
- level_o=0, trc_valid_o=0, trc_last_o=0, trc_data_o=0;
- drop_cnt_o=0, pending_drop=0.
REQ-035 Reset asserted mid-record SHALL abandon the record with no further beats.
REQ-036 No capture SHALL occur on the first edge after reset deassertion unless rvfi_valid && trace_en_i are sampled high at that edge.

Structure
REQ-037 The trace record struct, the header bit-position constants and the FSM state enum SHALL reside in the shared package ibexc_trace_pkg.
REQ-038 Storage SHALL be a sub-module ibexc_trace_fifo (synchronous, parameterised width/depth, push/pop/full/empty/level); the FSM and drop logic stay in the top.

Verification
REQ-039 Single retirement with order=5, pc=0x8000_0000, insn=0x0000_0013, rd=0, wdata=0, trc_ready_i=1 -> beats 0x0000_0005, 0x8000_0000, 0x0000_0013, 0x0; last on beat 4; first beat 1 cycle after capture.
REQ-040 Depth=8, trc_ready_i=0, 10 consecutive retirements -> level_o=8 and drop_cnt_o=2; after release, the first 8 records drain in order, and the next record stored afterwards has header[31]=1.
REQ-041 FIFO full, ready=1, and a new retirement in the same cycle as a WDATA handshake -> no drop and level_o stays 8.
REQ-042 Random trc_ready_i backpressure -> data and last stable while stalled, and the order field increments without gaps.
REQ-043 rst_i pulsed during the PC beat -> trc_valid_o=0 immediately, level_o=0, drop_cnt_o=0; a retirement after release emits normally.
REQ-044 drop_cnt_o preloaded to 0xFFFF by drops, then a further drop -> stays 0xFFFF; drop_clr_i coincident with a drop -> value 1.
